// File: rtl/stack_calc_pkg.sv
// ---------------------------------------------------------------------------
// stack_calc_pkg
// Shared definitions for the stack calculator: opcode encodings, the
// controller state type and small opcode classification helpers.
// ---------------------------------------------------------------------------
package stack_calc_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_PUSH   = 4'h1,
        OP_POP    = 4'h2,
        OP_DUP    = 4'h3,
        OP_SWAP   = 4'h4,
        OP_OVER   = 4'h5,
        OP_ADD    = 4'h6,
        OP_SUB    = 4'h7,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOT    = 4'hB,
        OP_SHL1   = 4'hC,
        OP_SHR1   = 4'hD,
        OP_MUL    = 4'hE,
        OP_CLRERR = 4'hF
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Number of stack entries an opcode consumes as operands.
    function automatic logic [1:0] op_arity(input op_e op);
        case (op)
            OP_POP, OP_DUP, OP_NOT, OP_SHL1, OP_SHR1:
                op_arity = 2'd1;
            OP_SWAP, OP_OVER, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL:
                op_arity = 2'd2;
            default:
                op_arity = 2'd0;
        endcase
    endfunction

    // Opcodes that add one entry without consuming any.
    function automatic logic op_grows(input op_e op);
        case (op)
            OP_PUSH, OP_DUP, OP_OVER: op_grows = 1'b1;
            default:                  op_grows = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stack_calc_mul.sv
// ---------------------------------------------------------------------------
// stack_calc_mul
// Sequential shift-add multiplier returning the low WIDTH bits of a*b.
// A job started on a rising edge with start=1 runs WIDTH steps. The first
// WIDTH-1 steps are registered; the last step is presented combinationally
// on product while done=1, so the caller captures the result on the WIDTH-th
// edge after start.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a running job)
//   start      begin a job with operands a, b (ignored while busy)
//   a, b       operands
//   busy       a job is in progress
//   done       final step is on product this cycle
//   product    low WIDTH bits of a*b, valid while done=1
// ---------------------------------------------------------------------------
module stack_calc_mul
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] step_s;

    // Partial product after adding the current multiplicand if the multiplier LSB is set.
    always_comb begin
        if (mplier_r[0]) begin
            step_s = acc_r + mcand_r;
        end else begin
            step_s = acc_r;
        end
    end

    // Load operands on start, then one shift-add step per cycle until the count expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (start && (count_r == {CW{1'b0}})) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
            count_r  <= CW'(WIDTH);
        end else if (count_r != {CW{1'b0}}) begin
            acc_r    <= step_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            count_r  <= count_r - CW'(1);
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            count_r  <= count_r;
        end
    end

    assign busy    = (count_r != {CW{1'b0}});
    assign done    = (count_r == CW'(1));
    assign product = step_s;

endmodule

// File: rtl/stack_calc_core.sv
// ---------------------------------------------------------------------------
// stack_calc_core
// Stack-machine calculator. Entry 0 of the internal storage is always the top
// of stack; pushes shift the storage down, pops shift it up. Every op except
// MUL completes in one cycle; MUL hands the two top entries to a sequential
// multiplier and blocks further ops for WIDTH cycles.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   op_valid    an op is offered; taken when op_ready=1
//   op          opcode (see stack_calc_pkg::op_e)
//   operand     PUSH value
//   op_ready    core idle and able to accept an op
//   top         top-of-stack value, 0 when empty
//   depth       number of valid entries
//   carry       ADD carry-out / SUB borrow, held by other ops
//   err_under   sticky: an op found too few operands
//   err_over    sticky: a push was attempted on a full stack
// ---------------------------------------------------------------------------
module stack_calc_core
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    input  logic [3:0]                 op,
    input  logic [WIDTH-1:0]           operand,
    output logic                       op_ready,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       carry,
    output logic                       err_under,
    output logic                       err_over
);

    localparam int             DW         = $clog2(DEPTH + 1);
    localparam logic [DW-1:0]  DEPTH_FULL = DW'(DEPTH);

    op_e              op_s;
    state_e           state_r, state_nxt_s;
    logic [WIDTH-1:0] stk_r       [DEPTH];
    logic [WIDTH-1:0] stk_nxt_s   [DEPTH];
    logic [WIDTH-1:0] sh_up_s     [DEPTH];
    logic [WIDTH-1:0] sh_dn_s     [DEPTH];
    logic [DW-1:0]    depth_r, depth_nxt_s;
    logic             carry_r, carry_nxt_s;
    logic             err_under_r, err_under_nxt_s;
    logic             err_over_r, err_over_nxt_s;
    logic [WIDTH-1:0] top_r;
    logic             op_ready_r;

    logic [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_s;
    logic             alu_carry_s;
    logic [WIDTH-1:0] push_val_s;

    logic             mul_start_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;

    assign op_s  = op_e'(op);
    assign b_s   = stk_r[0];
    assign a_s   = stk_r[1];
    assign sum_s = {1'b0, a_s} + {1'b0, b_s};

    stack_calc_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (a_s),
        .b       (b_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle ALU result for binary and unary ops, plus the resulting carry.
    always_comb begin
        alu_s       = b_s;
        alu_carry_s = carry_r;
        case (op_s)
            OP_ADD: begin
                alu_s       = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                alu_s       = a_s - b_s;
                alu_carry_s = (a_s < b_s);
            end
            OP_AND:  alu_s = a_s & b_s;
            OP_OR:   alu_s = a_s | b_s;
            OP_XOR:  alu_s = a_s ^ b_s;
            OP_NOT:  alu_s = ~b_s;
            OP_SHL1: alu_s = {b_s[WIDTH-2:0], 1'b0};
            OP_SHR1: alu_s = {1'b0, b_s[WIDTH-1:1]};
            default: alu_s = b_s;
        endcase
    end

    // Value placed on top by the growing ops.
    always_comb begin
        case (op_s)
            OP_DUP:  push_val_s = b_s;
            OP_OVER: push_val_s = a_s;
            default: push_val_s = operand;
        endcase
    end

    // Storage shifted one place toward the top (pop) and away from it (push).
    always_comb begin
        sh_up_s = stk_r;
        sh_dn_s = stk_r;
        for (int i = 0; i < DEPTH - 1; i++) begin
            sh_up_s[i]     = stk_r[i + 1];
            sh_dn_s[i + 1] = stk_r[i];
        end
    end

    // Controller: operand/capacity checks, op execution and MUL sequencing.
    always_comb begin
        stk_nxt_s       = stk_r;
        depth_nxt_s     = depth_r;
        carry_nxt_s     = carry_r;
        err_under_nxt_s = err_under_r;
        err_over_nxt_s  = err_over_r;
        state_nxt_s     = state_r;
        mul_start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    // Operand shortage outranks a full stack; both still consume the op.
                    if (depth_r < DW'(op_arity(op_s))) begin
                        err_under_nxt_s = 1'b1;
                    end else if (op_grows(op_s) && (depth_r == DEPTH_FULL)) begin
                        err_over_nxt_s = 1'b1;
                    end else begin
                        case (op_s)
                            OP_PUSH, OP_DUP, OP_OVER: begin
                                stk_nxt_s    = sh_dn_s;
                                stk_nxt_s[0] = push_val_s;
                                depth_nxt_s  = depth_r + DW'(1);
                            end
                            OP_POP: begin
                                stk_nxt_s   = sh_up_s;
                                depth_nxt_s = depth_r - DW'(1);
                            end
                            OP_SWAP: begin
                                stk_nxt_s[0] = a_s;
                                stk_nxt_s[1] = b_s;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                stk_nxt_s    = sh_up_s;
                                stk_nxt_s[0] = alu_s;
                                depth_nxt_s  = depth_r - DW'(1);
                                carry_nxt_s  = alu_carry_s;
                            end
                            OP_NOT, OP_SHL1, OP_SHR1: begin
                                stk_nxt_s[0] = alu_s;
                            end
                            OP_MUL: begin
                                mul_start_s = 1'b1;
                                state_nxt_s = ST_MUL;
                            end
                            OP_CLRERR: begin
                                err_under_nxt_s = 1'b0;
                                err_over_nxt_s  = 1'b0;
                            end
                            default: begin
                                stk_nxt_s = stk_r;
                            end
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    stk_nxt_s    = sh_up_s;
                    stk_nxt_s[0] = mul_product_s;
                    depth_nxt_s  = depth_r - DW'(1);
                    state_nxt_s  = ST_IDLE;
                end else if (!mul_busy_s) begin
                    // Multiplier has no job: return to IDLE rather than stall forever.
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control/status registers; top and op_ready are registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            depth_r     <= {DW{1'b0}};
            carry_r     <= 1'b0;
            err_under_r <= 1'b0;
            err_over_r  <= 1'b0;
            top_r       <= {WIDTH{1'b0}};
            op_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            depth_r     <= depth_nxt_s;
            carry_r     <= carry_nxt_s;
            err_under_r <= err_under_nxt_s;
            err_over_r  <= err_over_nxt_s;
            top_r       <= (depth_nxt_s == {DW{1'b0}}) ? {WIDTH{1'b0}} : stk_nxt_s[0];
            op_ready_r  <= (state_nxt_s == ST_IDLE);
        end
    end

    // Stack storage; entries beyond depth are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        stk_r <= stk_nxt_s;
    end

    assign op_ready  = op_ready_r;
    assign top       = top_r;
    assign depth     = depth_r;
    assign carry     = carry_r;
    assign err_under = err_under_r;
    assign err_over  = err_over_r;

endmodule

// File: doc/stack_calc_core.md
STACK_CALC_CORE -- requirements
Module: stack_calc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data/stack entry width, legal range 4..32.
REQ-002 SHALL have parameter DEPTH, default 8: number of stack entries, legal range 2..64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port op_valid, input, 1 bit: an op is offered.
REQ-006 SHALL have port op, input, 4 bits: opcode.
REQ-007 SHALL have port operand, input, WIDTH bits: PUSH value, ignored by other ops.
REQ-008 SHALL have port op_ready, output, 1 bit: the core can accept an op.
REQ-009 SHALL have port top, output, WIDTH bits: top-of-stack value, 0 when empty.
REQ-010 SHALL have port depth, output, $clog2(DEPTH+1) bits: current entry count.
REQ-011 SHALL have port carry, output, 1 bit: ADD carry-out / SUB borrow.
REQ-012 SHALL have port err_under, output, 1 bit: sticky underflow flag.
REQ-013 SHALL have port err_over, output, 1 bit: sticky overflow flag.

Function
REQ-014 An op SHALL be accepted on a rising edge with op_valid=1 and op_ready=1; top/depth/flags SHALL reflect a single-cycle op on the following cycle.
REQ-015 Opcodes SHALL be: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 ADD, 7 SUB, 8 AND, 9 OR, A XOR, B NOT, C SHL1, D SHR1 (logical), E MUL, F CLRERR.
REQ-016 With b=top and a=entry below top, binary ops (ADD..XOR, MUL) SHALL pop a and b and push a OP b; SUB SHALL compute a-b.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH; ADD SHALL set carry to the carry-out, SUB SHALL set carry=1 iff a<b, and all other ops SHALL hold carry.
REQ-018 Unary ops (NOT, SHL1, SHR1) SHALL replace top in place; DUP SHALL push b; OVER SHALL push a; SWAP SHALL exchange a and b.
REQ-019 An op requiring n operands when depth<n SHALL set err_under and leave stack, depth and carry unchanged.
REQ-020 PUSH, DUP or OVER at depth=DEPTH SHALL set err_over and leave the stack unchanged; an operand check that fails SHALL take precedence over the capacity check.
REQ-021 CLRERR SHALL clear both error flags in one cycle and leave the stack unchanged; error flags SHALL otherwise persist until reset, and an erroring op SHALL still be consumed.
REQ-022 MUL SHALL be a shift-add FSM IDLE->MUL->IDLE; op_ready SHALL be 0 for exactly WIDTH cycles after acceptance, after which the low WIDTH bits of the product are pushed and op_ready returns to 1.
REQ-023 During MUL, op_valid SHALL be ignored; a MUL rejected by REQ-019 SHALL NOT enter the MUL state.
REQ-024 op_ready SHALL be 1 in IDLE and 0 only in MUL.

Reset
REQ-025 rst=1 at a rising edge SHALL force depth=0, top=0, carry=0, err_under=0, err_over=0, op_ready=1 and state=IDLE, including mid-MUL (abort, no push).
REQ-026 Stack storage contents SHALL NOT require reset; top SHALL read 0 whenever depth=0.

Structure
REQ-027 Opcode encodings and the FSM state type SHALL live in shared package stack_calc_pkg.
REQ-028 The sequential multiplier SHALL be a sub-module stack_calc_mul (start, a, b, busy, done, product) parameterised by WIDTH.

Verification (WIDTH=8, DEPTH=4)
REQ-029 PUSH 3, PUSH 5, ADD -> top=8, depth=1, carry=0.
REQ-030 PUSH 200, PUSH 100, ADD -> top=44, carry=1; then PUSH 50, SUB -> top=250, carry=1.
REQ-031 PUSH 12, PUSH 13, MUL -> op_ready=0 for 8 cycles, then top=156, depth=1.
REQ-032 PUSH 1,2,3,4 then PUSH 9 -> err_over=1, depth=4, top=4; CLRERR -> err_over=0.
REQ-033 From empty, ADD -> err_under=1, depth=0, top=0; DUP on depth 0 -> err_under stays 1.
REQ-034 rst pulsed 3 cycles into a MUL -> next cycle depth=0, op_ready=1, all flags 0.
